// File: rtl/serial_frame_pkg.sv
// Shared definitions for the framed serial receiver.
//   rx_state_t      : receiver FSM states
//   clk_cnt_width() : width of the bit-timing divider counter
//   bit_cnt_width() : width of the received-bit counter
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Divider counts CLKS_PER_BIT-1 down to 0; at least one bit wide.
    function automatic int clk_cnt_width(input int clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

    // Bit counter runs 0..WIDTH, so it needs one extra code point.
    function automatic int bit_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_frame_rx_ctrl_shift_reg_en.sv
// shift_reg_en: WIDTH-bit serial-in / parallel-out register.
//   clk : clock, rising edge
//   clr : synchronous active-high clear (wins over en)
//   en  : shift enable; new bit enters at the LSB, MSB falls out
//   sin : serial input bit
//   q   : parallel contents
module shift_reg_en
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = {q_q[WIDTH-2:0], sin};
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/serial_frame_rx_ctrl.sv
// serial_frame_rx_ctrl: receives frames of
//   start(0), WIDTH data bits MSB first, [even parity], stop(1)
// and presents each good word through a one-entry valid/ready buffer.
//   Clk, Rst     : clock and synchronous active-high reset
//   Serial_In    : idle-high serial line, already in the Clk domain
//   Data_Out     : buffered word
//   Data_Valid   : buffer holds an unconsumed word
//   Data_Ready   : consumer accepts the word
//   Frame_Err    : one-cycle pulse on bad stop bit or parity mismatch
//   Overrun      : one-cycle pulse when a good frame finds the buffer full
//   Busy         : receiver is inside a frame (state != IDLE)
//   dbg_state    : current FSM state, for observation only
//
// Handshake: a word transfers on every rising edge where Data_Valid and
// Data_Ready are both 1. Data_Out is held constant while Data_Valid is 1
// and no transfer has happened. A new word may be loaded on the same edge
// the old one transfers, so Data_Valid stays high with no bubble.
module serial_frame_rx_ctrl
    import serial_frame_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Serial_In,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Data_Valid,
    input  logic             Data_Ready,
    output logic             Frame_Err,
    output logic             Overrun,
    output logic             Busy,
    output logic [2:0]       dbg_state
);

    localparam int CNT_W = clk_cnt_width(CLKS_PER_BIT);
    localparam int BIT_W = bit_cnt_width(WIDTH);

    // Half-bit load centres later samples in the middle of each bit.
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(WIDTH - 1);

    rx_state_t        state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             par_err_q, par_err_d;
    logic [WIDTH-1:0] data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             ferr_q,    ferr_d;
    logic             ovr_q,     ovr_d;

    logic             shift_en;
    logic             shreg_clr;
    logic [WIDTH-1:0] shreg;
    logic             expired;

    shift_reg_en #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk (Clk),
        .clr (Rst | shreg_clr),
        .en  (shift_en),
        .sin (Serial_In),
        .q   (shreg)
    );

    assign expired = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        par_err_d = par_err_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        shift_en  = 1'b0;
        shreg_clr = 1'b0;

        // Consumer transfer; a load below may immediately refill the buffer.
        if (valid_q && Data_Ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!Serial_In) begin
                    cnt_d   = HALF_RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (Serial_In) begin
                    // Line went back high before mid-bit: treat as noise.
                    state_d = IDLE;
                end else begin
                    cnt_d     = FULL_RELOAD;
                    bit_cnt_d = '0;
                    par_err_d = 1'b0;
                    shreg_clr = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_en  = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    cnt_d     = FULL_RELOAD;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_err_d = (^shreg) ^ Serial_In;
                    cnt_d     = FULL_RELOAD;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (!expired) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    if (!Serial_In || par_err_q) begin
                        ferr_d = 1'b1;
                    end else if (!valid_q || Data_Ready) begin
                        data_d  = shreg;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign Data_Out   = data_q;
    assign Data_Valid = valid_q;
    assign Frame_Err  = ferr_q;
    assign Overrun    = ovr_q;
    assign Busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule
